// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store engine in front of a word-wide
// data memory (DM) that has a multi-cycle synchronous read.
//
// Configuration macro: LSU_SUBWORD_EN
//   defined   -> byte/half loads (sign/zero extended) and sub-word stores
//                implemented as a read-modify-write of the containing word.
//   undefined -> every access is a whole word; req_size/req_unsigned are
//                ignored and any addr[1:0] != 0 is reported as an error.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_size,         store flag, access size (00 B, 01 H, 10 W),
//   req_unsigned              zero-extend loads
//   req_addr, req_wdata       byte address, store data
//   resp_valid/rdata/err      one-cycle response (no backpressure)
//   DM_*                      data-memory word port
module load_store_unit #(
    parameter int bit_size = 32,
    parameter int mem_size = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [mem_size+1:0]   req_addr,
    input  logic [bit_size-1:0]   req_wdata,
    output logic                  resp_valid,
    output logic [bit_size-1:0]   resp_rdata,
    output logic                  resp_err,
    output logic [mem_size-1:0]   DM_Address,
    output logic                  DM_en_Read,
    output logic                  DM_en_Write,
    output logic [bit_size-1:0]   DM_Write_Data,
    input  logic [bit_size-1:0]   DM_Read_Data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_HOLD  = 3'd2,
        RD_DATA  = 3'd3,
        WR       = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic                  we_r;
    logic                  err_r;
    logic [mem_size-1:0]   waddr_r;
    logic [bit_size-1:0]   wdata_r;
    logic [bit_size-1:0]   rdata_r;
    logic [bit_size-1:0]   load_val;

    logic accept;
    logic misaligned;
    logic is_word;

    assign accept = req_valid && (state == IDLE);

`ifdef LSU_SUBWORD_EN
    logic [1:0]          size_r;
    logic                uns_r;
    logic [1:0]          lane_r;
    logic [4:0]          sh;
    logic [bit_size-1:0] shifted;
    logic [bit_size-1:0] mask;
    logic [bit_size-1:0] merged;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end
    assign is_word = (req_size == 2'b10);

    // Little-endian: lane n occupies bits [8n+7:8n] of the memory word.
    assign sh      = {lane_r, 3'b000};
    assign shifted = DM_Read_Data >> sh;

    always_comb begin
        load_val = shifted;  // word access: lane_r is 0, so this is the whole word
        case (size_r)
            2'b00: load_val = uns_r ? {{(bit_size-8){1'b0}}, shifted[7:0]}
                                    : {{(bit_size-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_val = uns_r ? {{(bit_size-16){1'b0}}, shifted[15:0]}
                                    : {{(bit_size-16){shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Sub-word store: keep the untouched lanes of the word just read.
    assign mask   = ((size_r == 2'b00) ? bit_size'(8'hFF) : bit_size'(16'hFFFF)) << sh;
    assign merged = (DM_Read_Data & ~mask) | ((wdata_r << sh) & mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_r <= 2'b10;
            uns_r  <= 1'b0;
            lane_r <= 2'b00;
        end else if (accept) begin
            size_r <= req_size;
            uns_r  <= req_unsigned;
            lane_r <= req_addr[1:0];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{req_size, req_unsigned};
    assign misaligned = |req_addr[1:0];
    assign is_word    = 1'b1;
    assign load_val   = DM_Read_Data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)           state_nxt = RESP;
                    else if (req_we && is_word) state_nxt = WR;
                    else                      state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_HOLD;
            RD_HOLD:  state_nxt = RD_DATA;
`ifdef LSU_SUBWORD_EN
            RD_DATA:  state_nxt = we_r ? WR : RESP;
`else
            RD_DATA:  state_nxt = RESP;
`endif
            WR:       state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            if (accept) begin
                we_r    <= req_we;
                err_r   <= misaligned;
                waddr_r <= req_addr[mem_size+1:2];
                wdata_r <= req_wdata;
                if (misaligned) rdata_r <= '0;
            end
            // Read data is only trusted two cycles after the read strobe.
            if (state == RD_DATA) begin
                if (!we_r) rdata_r <= load_val;
`ifdef LSU_SUBWORD_EN
                else       wdata_r <= merged;
`endif
            end
        end
    end

    // Outputs are decoded from state so reset clears them without a clock.
    assign req_ready     = (state == IDLE);
    assign DM_en_Read    = (state == RD_ISSUE);
    assign DM_en_Write   = (state == WR);
    assign DM_Address    = (state == RD_ISSUE || state == RD_HOLD || state == WR) ? waddr_r : '0;
    assign DM_Write_Data = (state == WR) ? wdata_r : '0;
    assign resp_valid    = (state == RESP);
    assign resp_err      = (state == RESP) && err_r;
    assign resp_rdata    = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] DM_Address;
    logic        DM_en_Read;
    logic        DM_en_Write;
    logic [31:0] DM_Write_Data;
    logic [31:0] DM_Read_Data = '0;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [31:0] mem [0:15];

    load_store_unit #(.bit_size(32), .mem_size(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DM_Address(DM_Address), .DM_en_Read(DM_en_Read), .DM_en_Write(DM_en_Write),
        .DM_Write_Data(DM_Write_Data), .DM_Read_Data(DM_Read_Data)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read and write.
    always @(posedge clk) begin
        if (DM_en_Read)  DM_Read_Data <= mem[DM_Address[3:0]];
        if (DM_en_Write) mem[DM_Address[3:0]] <= DM_Write_Data;
    end

    // Strobe rules: never both, neither while idle or responding.
    always @(negedge clk) begin
        if (DM_en_Read && DM_en_Write) viol++;
        if ((req_ready || resp_valid) && (DM_en_Read || DM_en_Write)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          r_lat, r_rd, r_wr, r_wr_n;
    logic [31:0] r_wr_addr, r_wr_data, r_rdata;
    logic        r_err;

    // Issue one request and watch it until resp_valid (n = cycles after accept edge).
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [17:0] addr, input logic [31:0] wdata);
        r_lat = 0; r_rd = 0; r_wr = 0; r_wr_n = 0;
        r_wr_addr = '0; r_wr_data = '0; r_rdata = '0; r_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (DM_en_Read) r_rd++;
            if (DM_en_Write) begin
                r_wr++; r_wr_n = n;
                r_wr_addr = {16'h0, DM_Address}; r_wr_data = DM_Write_Data;
            end
            if (resp_valid) begin
                r_lat = n; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h000000F0;
        mem[2] = 32'h11223344;
        mem[3] = 32'h0BADF00D;

        // Reset state
        #2;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dm_en", {30'h0, DM_en_Read, DM_en_Write}, 32'h0);
        check("rst_dm_addr", {16'h0, DM_Address}, 32'h0);
        check("rst_dm_wdata", DM_Write_Data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Word store 0x10 <- DEADBEEF
        run_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF);
        check("wst_latency", r_lat, 32'd2);
        check("wst_wr_time", r_wr_n, 32'd1);
        check("wst_wr_addr", r_wr_addr, 32'h4);
        check("wst_wr_data", r_wr_data, 32'hDEADBEEF);
        check("wst_rd_cnt", r_rd, 32'd0);
        check("wst_err", {31'h0, r_err}, 32'h0);
        check("wst_rdata_kept", r_rdata, 32'h0);

        // Word load 0x10
        run_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0);
        check("wld_latency", r_lat, 32'd4);
        check("wld_rdata", r_rdata, 32'hDEADBEEF);
        check("wld_err", {31'h0, r_err}, 32'h0);
        check("wld_rd_cnt", r_rd, 32'd1);
        check("wld_wr_cnt", r_wr, 32'd0);
        @(negedge clk);
        check("wld_resp_one_cycle", {31'h0, resp_valid}, 32'h0);
        check("wld_rdata_hold", resp_rdata, 32'hDEADBEEF);
        check("wld_back_idle", {31'h0, req_ready}, 32'h1);

        // Misaligned word load 0x2
        run_req(1'b0, 2'b10, 1'b0, 18'h00002, 32'h0);
        check("mis_latency", r_lat, 32'd1);
        check("mis_err", {31'h0, r_err}, 32'h1);
        check("mis_rdata", r_rdata, 32'h0);
        check("mis_dm_cnt", r_rd + r_wr, 32'd0);

        // Byte load 0x4, word 1 = 000000F0
        run_req(1'b0, 2'b00, 1'b0, 18'h00004, 32'h0);
        check("bld_latency", r_lat, 32'd4);
        check("bld_err", {31'h0, r_err}, 32'h0);
`ifdef LSU_SUBWORD_EN
        check("bld_signed", r_rdata, 32'hFFFFFFF0);
        run_req(1'b0, 2'b00, 1'b1, 18'h00004, 32'h0);
        check("bld_unsigned", r_rdata, 32'h000000F0);

        // Half store 0x0A <- AAAA into 11223344
        run_req(1'b1, 2'b01, 1'b0, 18'h0000A, 32'h0000AAAA);
        check("hst_latency", r_lat, 32'd5);
        check("hst_rd_cnt", r_rd, 32'd1);
        check("hst_wr_cnt", r_wr, 32'd1);
        check("hst_wr_data", r_wr_data, 32'hAAAA3344);
        check("hst_wr_addr", r_wr_addr, 32'h2);

        run_req(1'b0, 2'b01, 1'b0, 18'h0000A, 32'h0);
        check("hld_signed", r_rdata, 32'hFFFFAAAA);
        run_req(1'b0, 2'b00, 1'b1, 18'h0000B, 32'h0);
        check("bld_lane3", r_rdata, 32'h000000AA);
        run_req(1'b0, 2'b01, 1'b0, 18'h0000B, 32'h0);
        check("hld_misaligned", {31'h0, r_err}, 32'h1);
        run_req(1'b0, 2'b11, 1'b0, 18'h00008, 32'h0);
        check("size11_err", {31'h0, r_err}, 32'h1);
`else
        check("bld_as_word", r_rdata, 32'h000000F0);

        // Half store request is a plain word store here
        run_req(1'b1, 2'b01, 1'b0, 18'h00008, 32'h5555AAAA);
        check("hst_as_word_latency", r_lat, 32'd2);
        check("hst_as_word_data", r_wr_data, 32'h5555AAAA);
        check("hst_as_word_rd_cnt", r_rd, 32'd0);

        run_req(1'b0, 2'b00, 1'b0, 18'h00005, 32'h0);
        check("byte_addr_err", {31'h0, r_err}, 32'h1);
`endif

        // Reset in the middle of a store to word 3
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_unsigned = 1'b0;
        req_addr = 18'h0000C; req_wdata = 32'h12345678;
`ifdef LSU_SUBWORD_EN
        req_size = 2'b01;
`else
        req_size = 2'b10;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_SUBWORD_EN
        @(negedge clk);  // now in RD_HOLD
`endif
        rst = 1'b0;
        #1;
        check("abort_outputs", {28'h0, DM_en_Read, DM_en_Write, resp_valid, resp_err}, 32'h0);
        check("abort_dm_addr", {16'h0, DM_Address}, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (DM_en_Write || resp_valid) seen++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (DM_en_Write || resp_valid) seen++;
        end
        check("abort_no_activity", seen, 32'd0);
        check("abort_mem_kept", mem[3], 32'h0BADF00D);

        // Recovery after the abort
        run_req(1'b0, 2'b10, 1'b0, 18'h0000C, 32'h0);
        check("recover_rdata", r_rdata, 32'h0BADF00D);
        check("recover_latency", r_lat, 32'd4);

        check("strobe_rules", viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
